// File: rtl/mac_dot_controller.sv
// mac_dot_controller: sequences dot-product commands from a vector memory port into a chunked MAC.
// Define MAC_CTRL_TIMEOUT_EN to add the DRAIN/WAIT_RES watchdog that drives errOut.
module mac_dot_controller #(
   parameter int FRAC_WIDTH     = 24,
   parameter int EXP_WIDTH      = 8,
   parameter int VECTOR_SIZE    = 8,
   parameter int LEN_WIDTH      = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                          clkIn,
   input  logic                                          rstIn,
   input  logic                                          cmdValidIn,
   output logic                                          cmdReadyOut,
   input  logic [LEN_WIDTH-1:0]                          cmdLenIn,
   input  logic [ADDR_WIDTH-1:0]                         cmdAddrAIn,
   input  logic [ADDR_WIDTH-1:0]                         cmdAddrBIn,
   output logic                                          memReqOut,
   input  logic                                          memReadyIn,
   output logic [ADDR_WIDTH-1:0]                         memAddrAOut,
   output logic [ADDR_WIDTH-1:0]                         memAddrBOut,
   input  logic                                          memValidIn,
   input  logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] memDataAIn,
   input  logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] memDataBIn,
   output logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] macDataAOut,
   output logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] macDataBOut,
   output logic [VECTOR_SIZE-1:0]                        macValidOut,
   output logic                                          macLastOut,
   input  logic [FRAC_WIDTH+EXP_WIDTH-1:0]               macResultIn,
   input  logic                                          macResultValidIn,
   output logic [FRAC_WIDTH+EXP_WIDTH-1:0]               resultOut,
   output logic                                          resultValidOut,
   input  logic                                          resultReadyIn,
   output logic                                          busyOut,
   output logic                                          errOut
);
   localparam int DW = FRAC_WIDTH + EXP_WIDTH;
   localparam int RW = $clog2(VECTOR_SIZE);
   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_RES, DONE} state_t;
   state_t state_q;
   logic [LEN_WIDTH-1:0] chunks_q, issue_cnt_q, ret_cnt_q, chunks_d, issue_cnt_d, ret_cnt_d;
   logic [RW-1:0] rem_q;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
   logic [DW*VECTOR_SIZE-1:0] mac_a_q, mac_b_q;
   logic [VECTOR_SIZE-1:0] mac_valid_q, last_mask;
   logic [DW-1:0] result_q;
   logic mac_last_q, issue_fire, ret_fire, last_issue, last_ret, timeout;
   assign chunks_d    = (cmdLenIn >> RW) + LEN_WIDTH'(|cmdLenIn[RW-1:0]);
   assign issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
   assign ret_cnt_d   = ret_cnt_q + LEN_WIDTH'(1);
   assign issue_fire  = state_q == ISSUE && memReadyIn;
   // returns beyond the chunk count are dropped so a misbehaving memory cannot overrun the MAC
   assign ret_fire    = (state_q == ISSUE || state_q == DRAIN) && memValidIn && ret_cnt_q != chunks_q;
   assign last_issue  = issue_fire && issue_cnt_d == chunks_q;
   assign last_ret    = ret_fire && ret_cnt_d == chunks_q;
   always_comb begin
      last_mask = '0;
      for (int i = 0; i < VECTOR_SIZE; i++) last_mask[i] = rem_q == '0 || RW'(i) < rem_q;
   end
`ifdef MAC_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;
   logic err_q, tmo_run;
   assign tmo_run = (state_q == DRAIN || state_q == WAIT_RES) && !memValidIn && !macResultValidIn;
   assign timeout = tmo_run && tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign errOut  = err_q;
   always_ff @(posedge clkIn or negedge rstIn)
      if (!rstIn) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (tmo_run && !timeout) ? tmo_q + TW'(1) : '0;
         err_q <= err_q | timeout;
      end
`else
   assign timeout = 1'b0;
   assign errOut  = 1'b0;
`endif
   always_ff @(posedge clkIn or negedge rstIn)
      if (!rstIn) begin
         state_q     <= IDLE;
         chunks_q    <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         rem_q       <= '0;
         addr_a_q    <= '0;
         addr_b_q    <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_valid_q <= '0;
         mac_last_q  <= 1'b0;
         result_q    <= '0;
      end else begin
         mac_valid_q <= '0;
         mac_last_q  <= 1'b0;
         if (issue_fire) begin
            issue_cnt_q <= issue_cnt_d;
            addr_a_q    <= addr_a_q + ADDR_WIDTH'(1);
            addr_b_q    <= addr_b_q + ADDR_WIDTH'(1);
         end
         if (ret_fire) begin
            ret_cnt_q   <= ret_cnt_d;
            mac_a_q     <= memDataAIn;
            mac_b_q     <= memDataBIn;
            mac_valid_q <= last_ret ? last_mask : '1;
            mac_last_q  <= last_ret;
         end
         if (timeout) begin
            result_q <= '1;
            state_q  <= DONE;
         end else begin
            case (state_q)
               IDLE: if (cmdValidIn) begin
                  chunks_q    <= chunks_d;
                  rem_q       <= cmdLenIn[RW-1:0];
                  addr_a_q    <= cmdAddrAIn;
                  addr_b_q    <= cmdAddrBIn;
                  issue_cnt_q <= '0;
                  ret_cnt_q   <= '0;
                  if (cmdLenIn == '0) result_q <= '0;
                  state_q     <= cmdLenIn == '0 ? DONE : ISSUE;
               end
               ISSUE:    state_q <= last_ret ? WAIT_RES : last_issue ? DRAIN : ISSUE;
               DRAIN:    state_q <= last_ret ? WAIT_RES : DRAIN;
               WAIT_RES: if (macResultValidIn) begin
                  result_q <= macResultIn;
                  state_q  <= DONE;
               end
               DONE:     state_q <= resultReadyIn ? IDLE : DONE;
               default:  state_q <= IDLE;
            endcase
         end
      end
   assign cmdReadyOut    = state_q == IDLE;
   assign busyOut        = state_q != IDLE;
   assign memReqOut      = state_q == ISSUE;
   assign resultValidOut = state_q == DONE;
   assign memAddrAOut    = addr_a_q;
   assign memAddrBOut    = addr_b_q;
   assign macDataAOut    = mac_a_q;
   assign macDataBOut    = mac_b_q;
   assign macValidOut    = mac_valid_q;
   assign macLastOut     = mac_last_q;
   assign resultOut      = result_q;
endmodule
